// File: rtl/cfg_stream_loader.sv
// cfg_stream_loader
//   Feeds a tile's configuration shift chain. Bitstream words arrive over a
//   valid/ready handshake and are shifted out LSB-first while cfg_cen is high.
//   After exactly CHAIN_LEN bits the enable drops and a single cfg_set pulse
//   commits the configuration.
//
//   Ports:
//     clk, rst            clock, asynchronous active-low reset
//     start, abort        begin a load / cancel an in-progress load
//     word_data/valid     incoming bitstream word and its valid
//     word_ready          loader is waiting for a word
//     cfg_cen/shift/set   shift enable, serial bit, commit pulse to the tile
//     busy, done          load in progress / last load committed
//     bits_left           chain bits still to shift
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   IDLE      | no load; after reset or abort
//   WAIT_WORD | word_ready high, waiting for the next word
//   SHIFT     | cfg_cen high, one bit per cycle from shreg[0]
//   SET       | one-cycle cfg_set commit pulse
//   DONE      | load committed; done held until the next start
module cfg_stream_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cfg_cen,
    output logic              cfg_shift,
    output logic              cfg_set,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_left
);
    localparam int WC_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        SET,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WORD_W-1:0] shreg;
    logic [WC_W-1:0]   word_cnt;
    logic [WC_W-1:0]   word_cnt_load;
    logic              start_ok;
    logic              abort_ok;
    logic              accept;
    logic              last_bit;
    logic              last_of_word;

    assign start_ok     = start && ((state == IDLE) || (state == DONE));
    assign abort_ok     = abort && ((state == WAIT_WORD) || (state == SHIFT));
    assign accept       = (state == WAIT_WORD) && word_valid;
    assign last_bit     = (bits_left == CNT_W'(1));
    assign last_of_word = (word_cnt == WC_W'(1));

    // A partial last word only shifts the bits the chain still needs.
    always_comb begin
        if (32'(bits_left) < WORD_W) begin
            word_cnt_load = WC_W'(bits_left);
        end else begin
            word_cnt_load = WC_W'(WORD_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        word_ready = 1'b0;
        cfg_cen    = 1'b0;
        cfg_shift  = 1'b0;
        cfg_set    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = WAIT_WORD;
            end
            WAIT_WORD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                // abort beats a handshake on the same edge
                if (abort) begin
                    state_nxt = IDLE;
                end else if (word_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                cfg_cen   = 1'b1;
                cfg_shift = shreg[0];
                busy      = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (last_bit) begin
                    state_nxt = SET;
                end else if (last_of_word) begin
                    state_nxt = WAIT_WORD;
                end
            end
            SET: begin
                cfg_set   = 1'b1;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = WAIT_WORD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            word_cnt  <= '0;
            bits_left <= '0;
        end else if (start_ok) begin
            bits_left <= CNT_W'(CHAIN_LEN);
        end else if (abort_ok) begin
            shreg     <= '0;
            word_cnt  <= '0;
            bits_left <= '0;
        end else if (accept) begin
            shreg    <= word_data;
            word_cnt <= word_cnt_load;
        end else if (state == SHIFT) begin
            shreg     <= shreg >> 1;
            word_cnt  <= word_cnt - WC_W'(1);
            bits_left <= bits_left - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Bench for cfg_stream_loader: a 40-bit chain instance and a 5-bit chain
// instance (16-bit words) share stimulus; `sel` picks which one is driven and
// observed. Expected serial streams come from the word list alone.
module tb_cfg_stream_loader;
    localparam int W         = 16;
    localparam int BIG_LEN   = 40;
    localparam int SMALL_LEN = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         word_valid;
    logic [W-1:0] word_data;
    logic         sel;

    logic       b_ready, b_cen, b_shift, b_set, b_busy, b_done;
    logic [5:0] b_left;
    logic       s_ready, s_cen, s_shift, s_set, s_busy, s_done;
    logic [2:0] s_left;

    logic       mon_ready, mon_cen, mon_shift, mon_set, mon_busy, mon_done;
    logic [5:0] mon_left;

    logic [W-1:0] words[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cfg_stream_loader #(.WORD_W(W), .CHAIN_LEN(BIG_LEN)) u_big (
        .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
        .word_data(word_data), .word_valid(word_valid & ~sel),
        .word_ready(b_ready), .cfg_cen(b_cen), .cfg_shift(b_shift),
        .cfg_set(b_set), .busy(b_busy), .done(b_done), .bits_left(b_left)
    );

    cfg_stream_loader #(.WORD_W(W), .CHAIN_LEN(SMALL_LEN)) u_small (
        .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
        .word_data(word_data), .word_valid(word_valid & sel),
        .word_ready(s_ready), .cfg_cen(s_cen), .cfg_shift(s_shift),
        .cfg_set(s_set), .busy(s_busy), .done(s_done), .bits_left(s_left)
    );

    assign mon_ready = sel ? s_ready : b_ready;
    assign mon_cen   = sel ? s_cen   : b_cen;
    assign mon_shift = sel ? s_shift : b_shift;
    assign mon_set   = sel ? s_set   : b_set;
    assign mon_busy  = sel ? s_busy  : b_busy;
    assign mon_done  = sel ? s_done  : b_done;
    assign mon_left  = sel ? {3'b000, s_left} : b_left;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(mon_ready), 0);
        check({tag, "_cen"},   int'(mon_cen),   0);
        check({tag, "_shift"}, int'(mon_shift), 0);
        check({tag, "_set"},   int'(mon_set),   0);
        check({tag, "_busy"},  int'(mon_busy),  0);
        check({tag, "_done"},  int'(mon_done),  0);
        check({tag, "_left"},  int'(mon_left),  0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(W'($urandom));
    endtask

    // One load from start to done (or to an abort / reset). Entered and left
    // just after a rising edge with the DUT in IDLE or DONE.
    task automatic run_load(input int gap_lo, input int gap_hi, input bit poke,
                            input int abort_at, input bit abort_hs, input int rst_at);
        int clen, nw, widx, gap, hs, set_cnt, run_len, run_idx, cyc, exp_run;
        bit prev_cen, prev_ready, finished, aborted, was_reset;
        bit exp_bits[$];
        bit got_bits[$];
        clen = sel ? SMALL_LEN : BIG_LEN;
        nw   = (clen + W - 1) / W;
        for (int i = 0; i < clen; i++) exp_bits.push_back(words[i / W][i % W]);
        widx = 0; hs = 0; set_cnt = 0; run_len = 0; run_idx = 0; cyc = 0;
        prev_cen = 0; prev_ready = 0; finished = 0; aborted = 0; was_reset = 0;
        gap = $urandom_range(gap_hi, gap_lo);

        while (!finished && !aborted && !was_reset) begin
            start      = (cyc == 0) || (poke && mon_cen && got_bits.size() == clen / 2);
            word_valid = (widx < nw && gap == 0) || (poke && widx >= nw);
            word_data  = (widx < nw) ? words[widx] : W'($urandom);
            @(negedge clk);
            if (cyc == 1) begin
                check("left_at_start", int'(mon_left), clen);
                check("busy_at_start", int'(mon_busy), 1);
                check("done_cleared", int'(mon_done), 0);
            end
            check("cen_set_excl", int'(mon_cen & mon_set), 0);
            check("ready_cen_excl", int'(mon_ready & mon_cen), 0);
            if (mon_busy && !mon_cen && !mon_set)
                check("ready_while_waiting", int'(mon_ready), 1);
            if (mon_cen) begin
                if (!prev_cen) check("ready_before_run", int'(prev_ready), 1);
                got_bits.push_back(mon_shift);
                run_len++;
            end else if (prev_cen) begin
                exp_run = (clen - W * run_idx > W) ? W : clen - W * run_idx;
                check("run_len", run_len, exp_run);
                run_idx++;
                run_len = 0;
            end
            if (mon_set) begin
                set_cnt++;
                check("set_after_last_bit", int'(prev_cen), 1);
            end
            if (abort_at >= 0 && mon_cen && got_bits.size() == abort_at + 1) begin
                abort = 1'b1; aborted = 1;
            end
            if (abort_hs && mon_ready && word_valid && widx == 1) begin
                abort = 1'b1; aborted = 1;
            end
            if (word_valid && mon_ready && !abort) begin
                hs++; widx++;
                gap = $urandom_range(gap_hi, gap_lo);
            end else if (mon_ready && !word_valid && gap > 0) begin
                gap--;
            end
            if (rst_at >= 0 && mon_cen && got_bits.size() == rst_at + 1) begin
                rst = 1'b0;
                #1;
                check_all_zero("async_reset");
                was_reset = 1;
            end
            if (mon_done && cyc > 0) finished = 1;
            prev_cen   = mon_cen;
            prev_ready = mon_ready;
            @(posedge clk); #1;
            abort = 1'b0;
            cyc++;
            if (cyc > 500) begin
                check("load_timeout", 0, 1);
                break;
            end
        end
        start = 1'b0;

        if (was_reset) begin
            word_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("no_set_after_reset", int'(mon_set), 0);
                check("idle_after_reset", int'(mon_busy), 0);
            end
        end else if (aborted) begin
            @(negedge clk);
            check("abort_cen", int'(mon_cen), 0);
            check("abort_set", int'(mon_set), 0);
            check("abort_done", int'(mon_done), 0);
            check("abort_busy", int'(mon_busy), 0);
            check("abort_left", int'(mon_left), 0);
            repeat (3) begin
                @(negedge clk);
                check("abort_no_set", int'(mon_set | mon_cen), 0);
            end
        end else if (finished) begin
            check("handshakes", hs, nw);
            check("cen_cycles", got_bits.size(), clen);
            check("set_pulses", set_cnt, 1);
            for (int i = 0; i < clen && i < got_bits.size(); i++)
                check($sformatf("stream_bit%0d", i), int'(got_bits[i]), int'(exp_bits[i]));
            check("done_final", int'(mon_done), 1);
            check("busy_final", int'(mon_busy), 0);
            check("left_final", int'(mon_left), 0);
            repeat (3) begin
                @(negedge clk);
                check("done_hold", int'(mon_done), 1);
                check("done_no_ready", int'(mon_ready | mon_cen | mon_set), 0);
            end
        end
        word_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; word_valid = 1'b0;
        word_data = '0; sel = 1'b0;
        @(negedge clk);
        check_all_zero("reset_big");
        sel = 1'b1; #1;
        check_all_zero("reset_small");
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // fixed words, valid always high
        words.delete();
        words.push_back(16'hA5A5); words.push_back(16'h0F0F); words.push_back(16'h00C3);
        run_load(0, 0, 0, -1, 0, -1);
        // same words, five idle-valid cycles before each word
        run_load(5, 5, 0, -1, 0, -1);
        // abort during the 10th bit of word 2, then a clean load
        run_load(0, 0, 0, 25, 0, -1);
        rand_words(3);
        run_load(0, 3, 0, -1, 0, -1);
        // async reset mid-shift
        rand_words(3);
        run_load(0, 2, 0, -1, 0, 20);
        // start during SHIFT and valid during SET/DONE
        words.delete();
        words.push_back(16'hA5A5); words.push_back(16'h0F0F); words.push_back(16'h00C3);
        run_load(0, 0, 1, -1, 0, -1);
        // abort together with a handshake in WAIT_WORD
        rand_words(3);
        run_load(0, 0, 0, -1, 1, -1);
        for (int k = 0; k < 6; k++) begin
            rand_words(3);
            run_load(0, $urandom_range(6, 0), 1'($urandom_range(1, 0)), -1, 0, -1);
        end

        // short chain: only 5 bits of one word
        sel = 1'b1;
        words.delete();
        words.push_back(16'hFFF3);
        run_load(0, 0, 0, -1, 0, -1);
        for (int k = 0; k < 4; k++) begin
            rand_words(1);
            run_load(0, $urandom_range(4, 0), 1'($urandom_range(1, 0)), -1, 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
